// File: rtl/counter_scheduler_pkg.sv
// Shared types and the round-robin pick helper for the counter scheduler.
// Requester indices are carried at a fixed width, so up to MaxReq requesters are supported.
package counter_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } sched_state_t;

  localparam int unsigned MaxReq = 32;
  localparam int unsigned IdxW   = 5;

  typedef struct packed {
    logic            valid;
    logic [IdxW-1:0] idx;
  } rr_pick_t;

  // First set request searching upward from ptr+1, wrapping at n.
  function automatic rr_pick_t rr_pick(input logic [MaxReq-1:0] req,
                                       input logic [IdxW-1:0]   ptr,
                                       input int unsigned       n);
    rr_pick_t        r;
    int unsigned     j;
    logic [IdxW-1:0] jj;
    r = '0;
    for (int unsigned k = 1; k <= MaxReq; k++) begin
      j  = (32'(ptr) + k) % n;
      jj = IdxW'(j);
      if (k <= n && !r.valid && req[jj]) begin
        r.valid = 1'b1;
        r.idx   = jj;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/up_counter_core.sv
// Free-standing up-counter with synchronous clear and count enable.
module up_counter_core #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cuenta
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cuenta <= '0;
    end else if (clr) begin
      cuenta <= '0;
    end else if (en) begin
      cuenta <= cuenta + 1'b1;
    end
  end

endmodule

// File: rtl/counter_scheduler.sv
// Round-robin scheduler that lends one up-counter to N_REQ requesters, one interval at a time.
// Each granted interval lasts target+1 counted ticks and ends with a done pulse to the owner.
module counter_scheduler
  import counter_scheduler_pkg::*;
#(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned CNT_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*CNT_W-1:0] target,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       done,
  output logic                   busy,
  output logic [CNT_W-1:0]       cuenta
);

  sched_state_t      state;
  logic [IdxW-1:0]   rr_ptr;
  logic [IdxW-1:0]   owner;
  logic [CNT_W-1:0]  tgt_q;
  logic [MaxReq-1:0] req_ext;
  logic [CNT_W-1:0]  tgt_arr [MaxReq];
  rr_pick_t          pick;
  logic              owner_req;
  logic              at_tgt;
  logic              clr;
  logic              en;

  // Widen to the package index space so every select uses a full-width index.
  assign req_ext = MaxReq'(req);

  for (genvar i = 0; i < MaxReq; i++) begin : g_tgt
    if (i < N_REQ) begin : g_used
      assign tgt_arr[i] = target[i*CNT_W +: CNT_W];
    end else begin : g_unused
      assign tgt_arr[i] = '0;
    end
  end

  assign pick      = rr_pick(req_ext, rr_ptr, N_REQ);
  assign owner_req = req_ext[owner];
  assign at_tgt    = (cuenta == tgt_q);
  assign clr       = (state == IDLE) && pick.valid;
  assign en        = (state == COUNT) && owner_req && !at_tgt;
  assign busy      = (state != IDLE);

  up_counter_core #(
    .CNT_W (CNT_W)
  ) u_core (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr),
    .en     (en),
    .cuenta (cuenta)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      grant  <= '0;
      done   <= '0;
      tgt_q  <= '0;
      owner  <= '0;
      rr_ptr <= IdxW'(N_REQ - 1);
    end else begin
      unique case (state)
        IDLE: begin
          done <= '0;
          if (pick.valid) begin
            grant  <= N_REQ'(MaxReq'(1) << pick.idx);
            tgt_q  <= tgt_arr[pick.idx];
            owner  <= pick.idx;
            rr_ptr <= pick.idx;
            state  <= COUNT;
          end
        end
        COUNT: begin
          // A dropped request abandons the interval silently.
          if (!owner_req) begin
            grant <= '0;
            state <= IDLE;
          end else if (at_tgt) begin
            done  <= grant;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= '0;
          grant <= '0;
          state <= IDLE;
        end
        default: begin
          done  <= '0;
          grant <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
